// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - multi-cycle multiply/divide unit with HI/LO registers
// Define MDU_MADD_EN to enable MADD/MADDU (op codes 7/8) accumulate into {hi,lo}.
module mdu_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  localparam int MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [0:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   pend_hi;
  logic [WIDTH-1:0]   pend_lo;

  logic                      is_mul;
  logic                      is_div;
  logic [WIDTH-1:0]          res_hi;
  logic [WIDTH-1:0]          res_lo;
  logic signed [2*WIDTH-1:0] sext_a;
  logic signed [2*WIDTH-1:0] sext_b;
  logic signed [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic signed [WIDTH-1:0]   sdiv_a;
  logic signed [WIDTH-1:0]   sdiv_b;
  logic [WIDTH-1:0]          udiv_b;
  logic                      div_zero;
  logic                      div_ovf;

  always_comb begin
    is_mul   = 1'b0;
    is_div   = 1'b0;
    res_hi   = '0;
    res_lo   = '0;
    sext_a   = {{WIDTH{A[WIDTH-1]}}, A};
    sext_b   = {{WIDTH{B[WIDTH-1]}}, B};
    prod_s   = sext_a * sext_b;
    prod_u   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    div_zero = (B == '0);
    div_ovf  = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
    // Dividing the overflow case by 1 yields exactly lo=A, hi=0.
    sdiv_a   = A;
    sdiv_b   = (div_zero || div_ovf) ? WIDTH'(1) : B;
    udiv_b   = div_zero ? WIDTH'(1) : B;
    case (mdu_op)
      OP_MULT: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      OP_MULTU: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      OP_DIV: begin
        is_div = 1'b1;
        if (div_zero) begin
          res_hi = A;
          res_lo = '1;
        end else begin
          res_hi = sdiv_a % sdiv_b;
          res_lo = sdiv_a / sdiv_b;
        end
      end
      OP_DIVU: begin
        is_div = 1'b1;
        if (div_zero) begin
          res_hi = A;
          res_lo = '1;
        end else begin
          res_hi = A % udiv_b;
          res_lo = A / udiv_b;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_s;
      end
      OP_MADDU: begin
        is_mul = 1'b1;
        {res_hi, res_lo} = {hi, lo} + prod_u;
      end
`endif
      default: begin
        is_mul = 1'b0;
        is_div = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (flush) begin
      // Cancels an in-flight op and suppresses any same-cycle start.
      state   <= S_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_mul || is_div) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              cnt     <= is_mul ? MUL_LOAD : DIV_LOAD;
              state   <= S_BUSY;
              busy    <= 1'b1;
            end else if (mdu_op == OP_MTHI) begin
              hi <= A;
            end else if (mdu_op == OP_MTLO) begin
              lo <= A;
            end
          end
        end
        default: begin
          if (cnt == '0) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq against an arithmetic reference model
module tb_mdu_seq;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_seq #(.WIDTH(32), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op), .A(A), .B(B),
    .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          assertions = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          mon_en = 1'b0;
  logic        mon_pb = 1'b0;
  logic [63:0] mon_phl = '0;
  int          mon_bc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: architectural effect of one op on {hi,lo}, plus busy length.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output bit act, output logic [63:0] res, output int n);
    int sa, sbv;
    longint sp;
    logic [63:0] up;
    sa = a;
    sbv = b;
    sp = longint'(sa) * longint'(sbv);
    up = {32'b0, a} * {32'b0, b};
    act = 1'b1;
    n = 0;
    res = {m_hi, m_lo};
    case (op)
      4'd1: begin res = sp; n = MULN; end
      4'd2: begin res = up; n = MULN; end
      4'd3: begin
        n = DIVN;
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, a};
        else res = {32'(sa % sbv), 32'(sa / sbv)};
      end
      4'd4: begin
        n = DIVN;
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      4'd5: res = {a, m_lo};
      4'd6: res = {m_hi, a};
`ifdef MDU_MADD_EN
      4'd7: begin res = {m_hi, m_lo} + 64'(sp); n = MULN; end
      4'd8: begin res = {m_hi, m_lo} + up; n = MULN; end
`endif
      default: act = 1'b0;
    endcase
  endfunction

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
    bit act;
    logic [63:0] res;
    int n;
    exp_t e;
    model(op, a, b, act, res, n);
    if (act && (n > 0 || res != {m_hi, m_lo})) begin
      e.hi = res[63:32];
      e.lo = res[31:0];
      e.cycles = n;
      e.name = nm;
      sb.push_back(e);
    end
    if (act) {m_hi, m_lo} = res;
    @(negedge clk);
    start = 1'b1; mdu_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0; A = $urandom; B = $urandom;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      assertions++;
      failures++;
      $display("FAIL %s_timeout: busy still high after %0d cycles", nm, k);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
    launch(op, a, b, nm);
    wait_idle(nm);
    check({nm, "_state"}, {31'b0, busy, hi, lo}, {31'b0, 1'b0, m_hi, m_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: an output event is a busy fall or a hi/lo change while idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busy) mon_bc++;
        if ((mon_pb && !busy) || (!mon_pb && !busy && {hi, lo} != mon_phl)) begin
          if (sb.size() == 0) begin
            assertions++;
            failures++;
            $display("FAIL unexpected_output: hi=%h lo=%h busy_cycles=%0d with nothing expected", hi, lo, mon_bc);
          end else begin
            e = sb.pop_front();
            check({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
            check({e.name, "_busy_cycles"}, 64'(mon_bc), 64'(e.cycles));
          end
          mon_bc = 0;
        end
      end else begin
        mon_bc = 0;
      end
      mon_pb = busy;
      mon_phl = {hi, lo};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    int r;
    exp_t e;
    reset = 1'b0; start = 1'b0; flush = 1'b0; mdu_op = 4'd0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {31'b0, busy, hi, lo}, 64'h0);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    issue(4'd5, 32'h0000_ABCD, 32'h0, "mthi");
    issue(4'd6, 32'h0000_5555, 32'h0, "mtlo_pre");

    // Async reset in the middle of a divide.
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_reset", {63'b0, busy}, 64'h1);
    #2 reset = 1'b0;
    #1 check("async_reset", {31'b0, busy, hi, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    sb.delete();
    @(negedge clk);
    mon_en = 1'b1;

    issue(4'd6, 32'h0000_1234, 32'h0, "mtlo");
    check("mtlo_lo", {32'b0, lo}, 64'h1234);
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, "mult");
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    check("multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, "div");
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd4, 32'd7, 32'd0, "divu_by_zero");
    check("divu_zero_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(4'd3, 32'hFFFF_FFF9, 32'd0, "div_by_zero");

    // Flush on the fourth busy cycle of a divide.
    e.hi = m_hi; e.lo = m_lo; e.cycles = 4; e.name = "flush";
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_state", {31'b0, busy, hi, lo}, {31'b0, 1'b0, m_hi, m_lo});

    // Flush while idle suppresses a same-cycle start.
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd6; A = 32'hDEAD_0000; flush = 1'b1;
    @(negedge clk);
    start = 1'b1; mdu_op = 4'd1; A = 32'd9; B = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {31'b0, busy, hi, lo}, {31'b0, 1'b0, m_hi, m_lo});

    // Start while busy must be ignored.
    launch(4'd1, 32'h0000_1234, 32'h0000_0010, "mult_busy");
    start = 1'b1; mdu_op = 4'd1; A = 32'hFFFF_FFFF; B = 32'h7;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mult_busy");
    repeat (3) @(negedge clk);
    check("ignored_start", {31'b0, busy, hi, lo}, {31'b0, 1'b0, 32'h0, 32'h0001_2340});

    issue(4'd5, 32'h0, 32'h0, "madd_sethi");
    issue(4'd6, 32'hFFFF_FFFF, 32'h0, "madd_setlo");
    issue(4'd8, 32'd1, 32'd1, "maddu");
`ifdef MDU_MADD_EN
    check("maddu_const", {hi, lo}, 64'h0000_0001_0000_0000);
`else
    check("maddu_off_const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
`endif

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 11);
      op = (r < 9) ? 4'(r) : 4'(r + 3);
      issue(op, pick(), pick(), $sformatf("rand%0d_op%0d", i, op));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers.
- Successor to the combinational datapath ALU; sits in the EX stage next to it.
- Hazard/stall logic uses `busy` to stall the pipeline.
- Handles MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes, with fixed, parameter-set latencies and a flush for exception cancellation.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, cycles `busy` stays high for multiply ops; must be >= 1.
- DIV_CYCLES, 10, cycles `busy` stays high for divide ops; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe, sampled on rising clk.
- mdu_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; others treated as NONE.
- A  input  WIDTH  operand rs.
- B  input  WIDTH  operand rt.
- flush  input  1  abort in-progress op (exception/eret).
- busy  output  1  registered; high while a multiply/divide is in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, pending result 0, busy=0, hi=0, lo=0.
- States: IDLE and BUSY.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Compute the full result from A and B this cycle and latch it into the pending regs.
  - Load counter with N-1 (N = MUL_CYCLES or DIV_CYCLES). Go to BUSY; busy=1 from the next cycle.
- BUSY: counter decrements each cycle. When counter==0 at an edge, commit pending to hi/lo, set busy=0, return to IDLE.
  - Net: busy is high for exactly N cycles; the new hi/lo is visible the same cycle busy falls.
- IDLE, start=1, MTHI: hi<=A next edge, lo unchanged, busy stays 0. MTLO likewise writes lo.
- start while BUSY (any op): ignored. The pipeline guarantees a stall; the unit does not queue.
- start=1 with NONE/invalid op: no effect.
- MULT: signed WIDTH x WIDTH -> 2*WIDTH product; {hi,lo}=product. MULTU: unsigned.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of A. DIVU: unsigned.
- Divide by zero (B==0), DIV or DIVU: lo=all ones, hi=A. Still takes DIV_CYCLES.
- Signed overflow (A=most-negative, B=-1, DIV): lo=A, hi=0.
- flush=1: if BUSY, return to IDLE next edge, busy=0, hi/lo unchanged, pending discarded. If IDLE, any same-cycle start is ignored. flush has priority over start and over commit.
- hi/lo change only on commit, MTHI/MTLO, or reset.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 7 MADD (signed) and 8 MADDU (unsigned).
  - {hi,lo} <= {hi,lo} + A*B, modulo 2^(2*WIDTH).
  - The addend {hi,lo} is sampled at start; uses MUL_CYCLES latency.
- Not defined: codes 7 and 8 are invalid (no effect, busy stays 0).

Test Plan:
- Reset/MTLO/MTHI:
  - Assert reset low mid-BUSY -> busy=0, hi=0, lo=0 immediately, before the next clk edge.
  - After release, MTLO A=0x1234 -> lo=0x00001234 next cycle, busy never rises.
- MULT with MUL_CYCLES=5: A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; on fall hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU: same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV/DIVU/div-by-zero:
  - DIV A=-7 (0xFFFFFFF9), B=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
- Flush and ignored start:
  - Start DIV, flush at busy cycle 4 -> busy=0 next cycle, hi/lo retain prior values.
  - Start MULT while busy -> ignored, original result committed on schedule.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU A=1, B=1 -> after 5 cycles hi=1, lo=0. Same op with macro undefined -> no busy, hi/lo unchanged.
